// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage pipelined IEEE-754 adder/subtractor with generic
// EXP_W/FRAC_W, round-to-nearest-even, full special-value handling,
// exception flags {invalid, overflow, underflow, inexact, zero}, valid/ready
// flow control and an opaque tag carried with each operation.
// Optional build macro FP_ADDSUB_FTZ_EN: subnormal inputs and results are
// flushed to signed zero (no gradual underflow).
module fp_addsub_pipe #(
    parameter int  EXP_W  = 5,
    parameter int  FRAC_W = 10,
    parameter int  TAG_W  = 4,
    localparam int W      = 1 + EXP_W + FRAC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       out_flags
);
    localparam int E      = EXP_W;
    localparam int F      = FRAC_W;
    localparam int SW     = F + 4;        // hidden + fraction + guard/round/sticky
    localparam int AW     = 2 * F + 4;    // alignment window for the small operand
    localparam int LW     = $clog2(F + 5);
    localparam int STAGES = 3;
    localparam int EMAX   = (1 << E) - 1;
    localparam logic [W-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};
    localparam logic [4:0] FL_INV  = 5'b10000;
    localparam logic [4:0] FL_OVF  = 5'b01000;
    localparam logic [4:0] FL_UNF  = 5'b00100;
    localparam logic [4:0] FL_INX  = 5'b00010;
    localparam logic [4:0] FL_ZERO = 5'b00001;

    // ---------------- flow control ----------------
    logic [STAGES:1] vld_pipe;
    logic            ld1, ld2, ld3;

    assign ld3       = ~vld_pipe[3] | out_ready;
    assign ld2       = ~vld_pipe[2] | ld3;
    assign ld1       = ~vld_pipe[1] | ld2;
    assign in_ready  = ld1;
    assign out_valid = vld_pipe[3];

    // Stage valid bits; each stage loads when it is empty or draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            if (ld1) vld_pipe[1] <= in_valid;
            if (ld2) vld_pipe[2] <= vld_pipe[1];
            if (ld3) vld_pipe[3] <= vld_pipe[2];
        end
    end

    // ---------------- S1: unpack / classify / align ----------------
    logic         sa, sb, dnz;
    logic [E-1:0] ea, eb, e_big, e_sml, eb_eff, es_eff, d;
    logic [F-1:0] fa, fb, f_big, f_sml;
    logic         a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_ge;
    logic         s_big, s_sml;
    logic [F:0]   m_big, m_sml;
    logic [AW-1:0] wide;
    logic [SW-1:0] ali;
    logic         spc;
    logic [W-1:0] spc_res;
    logic [4:0]   spc_flg;

    // Classify operands, order by magnitude and align the smaller significand.
    always_comb begin
        sa  = in_a[W-1];
        sb  = in_b[W-1] ^ in_mode;
        ea  = in_a[W-2:F];
        eb  = in_b[W-2:F];
        fa  = in_a[F-1:0];
        fb  = in_b[F-1:0];
        dnz = 1'b0;
`ifdef FP_ADDSUB_FTZ_EN
        if (ea == '0) begin dnz = (fa != '0); fa = '0; end
        if (eb == '0) begin dnz = dnz | (fb != '0); fb = '0; end
`endif
        a_nan  = (&ea) & (|fa);
        b_nan  = (&eb) & (|fb);
        a_snan = a_nan & ~fa[F-1];
        b_snan = b_nan & ~fb[F-1];
        a_inf  = (&ea) & ~(|fa);
        b_inf  = (&eb) & ~(|fb);

        a_ge   = {ea, fa} >= {eb, fb};
        s_big  = a_ge ? sa : sb;
        s_sml  = a_ge ? sb : sa;
        e_big  = a_ge ? ea : eb;
        e_sml  = a_ge ? eb : ea;
        f_big  = a_ge ? fa : fb;
        f_sml  = a_ge ? fb : fa;
        m_big  = {|e_big, f_big};
        m_sml  = {|e_sml, f_sml};
        // subnormals share the exponent of the smallest normal
        eb_eff = (e_big == '0) ? E'(1) : e_big;
        es_eff = (e_sml == '0) ? E'(1) : e_sml;
        d      = eb_eff - es_eff;
        wide   = {m_sml, {(F+3){1'b0}}} >> d;
        if (int'(d) >= F + 3) ali = {{(F+3){1'b0}}, |m_sml};
        else                  ali = {wide[AW-1:F+1], |wide[F:0]};

        spc     = 1'b1;
        spc_res = QNAN;
        spc_flg = '0;
        if (a_nan | b_nan)                   spc_flg = (a_snan | b_snan) ? FL_INV : 5'b0;
        else if (a_inf & b_inf & (sa != sb)) spc_flg = FL_INV;
        else if (a_inf)                      spc_res = {sa, {E{1'b1}}, {F{1'b0}}};
        else if (b_inf)                      spc_res = {sb, {E{1'b1}}, {F{1'b0}}};
        else                                 spc = 1'b0;
    end

    logic             r1_sbig, r1_ssml, r1_spc, r1_dnz;
    logic [E-1:0]     r1_e;
    logic [F:0]       r1_mbig;
    logic [SW-1:0]    r1_ali;
    logic [W-1:0]     r1_spc_res;
    logic [4:0]       r1_spc_flg;
    logic [TAG_W-1:0] r1_tag;

    // S1 pipeline register.
    always_ff @(posedge clk) begin
        if (ld1) begin
            r1_sbig    <= s_big;
            r1_ssml    <= s_sml;
            r1_e       <= eb_eff;
            r1_mbig    <= m_big;
            r1_ali     <= ali;
            r1_spc     <= spc;
            r1_spc_res <= spc_res;
            r1_spc_flg <= spc_flg;
            r1_dnz     <= dnz;
            r1_tag     <= in_tag;
        end
    end

    // ---------------- S2: add / leading-zero count ----------------
    logic [F+4:0]  big_x, sml_x, sum;
    logic [LW-1:0] lzc;

    // Magnitude sum or difference; big >= small so the difference is never negative.
    always_comb begin
        big_x = {1'b0, r1_mbig, 3'b000};
        sml_x = {1'b0, r1_ali};
        sum   = (r1_sbig ^ r1_ssml) ? big_x - sml_x : big_x + sml_x;
    end

    // Leading zeros below the carry bit; highest set bit wins.
    always_comb begin
        lzc = LW'(F + 4);
        for (int i = 0; i <= F + 3; i++)
            if (sum[i]) lzc = LW'(F + 3 - i);
    end

    logic             r2_sbig, r2_ssml, r2_spc, r2_dnz;
    logic [F+4:0]     r2_sum;
    logic [LW-1:0]    r2_lzc;
    logic [E-1:0]     r2_e;
    logic [W-1:0]     r2_spc_res;
    logic [4:0]       r2_spc_flg;
    logic [TAG_W-1:0] r2_tag;

    // S2 pipeline register.
    always_ff @(posedge clk) begin
        if (ld2) begin
            r2_sbig    <= r1_sbig;
            r2_ssml    <= r1_ssml;
            r2_sum     <= sum;
            r2_lzc     <= lzc;
            r2_e       <= r1_e;
            r2_spc     <= r1_spc;
            r2_spc_res <= r1_spc_res;
            r2_spc_flg <= r1_spc_flg;
            r2_dnz     <= r1_dnz;
            r2_tag     <= r1_tag;
        end
    end

    // ---------------- S3: normalise / round / pack ----------------
    int            e_i, lz_i, sh_i, ex_i;
    logic [SW-1:0] norm;
    logic [F+1:0]  mant;
    logic          g_b, rs_b, inx, rup, tiny;
    logic [W-1:0]  res;
    logic [4:0]    flg;

    // Normalise, round to nearest even, then resolve overflow/zero/special results.
    always_comb begin
        e_i  = int'(r2_e);
        lz_i = int'(r2_lzc);
        sh_i = 0;
        if (r2_sum[F+4]) begin
            norm = {r2_sum[F+4:2], r2_sum[1] | r2_sum[0]};
            ex_i = e_i + 1;
        end else begin
`ifdef FP_ADDSUB_FTZ_EN
            sh_i = lz_i;
`else
            // never shift below the subnormal exponent
            sh_i = (lz_i < e_i - 1) ? lz_i : e_i - 1;
`endif
            norm = r2_sum[F+3:0] << sh_i;
            ex_i = e_i - sh_i;
        end
        tiny = ~norm[F+3];
        g_b  = norm[2];
        rs_b = |norm[1:0];
        inx  = g_b | rs_b;
        rup  = g_b & (rs_b | norm[3]);
        mant = {1'b0, norm[F+3:3]} + {{(F+1){1'b0}}, rup};
        if (mant[F+1]) begin
            mant = mant >> 1;
            ex_i = ex_i + 1;
        end

        res = '0;
        flg = '0;
        if (r2_spc) begin
            res = r2_spc_res;
            flg = r2_spc_flg;
        end else if (r2_sum == '0) begin
            // exact cancellation is +0 unless both addends were negative
            res = {r2_sbig & r2_ssml, {(W-1){1'b0}}};
            flg = FL_ZERO;
        end else if (ex_i >= EMAX) begin
            res = {r2_sbig, {E{1'b1}}, {F{1'b0}}};
            flg = FL_OVF | FL_INX;
`ifdef FP_ADDSUB_FTZ_EN
        end else if (ex_i < 1) begin
            res = {r2_sbig, {(W-1){1'b0}}};
            flg = FL_UNF | FL_INX | FL_ZERO;
`endif
        end else begin
            res = {r2_sbig, mant[F] ? E'(ex_i) : {E{1'b0}}, mant[F-1:0]};
            flg = {1'b0, 1'b0, tiny & inx, inx, 1'b0};
        end
        // a flushed subnormal operand means the result is not exact
        if (!r2_spc && r2_dnz) flg = flg | FL_UNF | FL_INX;
    end

    // Output register; held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result <= '0;
            out_tag    <= '0;
            out_flags  <= '0;
        end else if (ld3 && vld_pipe[2]) begin
            out_result <= res;
            out_tag    <= r2_tag;
            out_flags  <= flg;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: scoreboard bench for fp_addsub_pipe (fp16 default build).
module tb_fp_addsub_pipe;
    localparam int EW = 5, FW = 10, TW = 4, W = 16, NV = 20;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b0;
    logic          in_ready, out_valid;
    logic [W-1:0]  in_a = '0, in_b = '0, out_result;
    logic [TW-1:0] in_tag = '0, out_tag;
    logic [4:0]    out_flags;

    int checks = 0, failures = 0;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         mode;
        logic [W-1:0] res;
        logic [4:0]   flg;
    } vec_t;

    typedef struct packed {
        logic [W-1:0]  res;
        logic [TW-1:0] tag;
        logic [4:0]    flg;
    } exp_t;

    exp_t sbq[$];

    // flags: {invalid, overflow, underflow, inexact, zero}
    vec_t vt [NV] = '{
        '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 5'h00},
        '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 5'h01},
        '{16'h0001, 16'h0001, 1'b0, 16'h0002, 5'h00},
        '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 5'h02},
        '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 5'h02},
        '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 5'h0A},
        '{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 5'h10},
        '{16'h7D00, 16'h3C00, 1'b0, 16'h7E00, 5'h10},
        '{16'h3C00, 16'hBC00, 1'b0, 16'h0000, 5'h01},
        '{16'h8000, 16'h8000, 1'b0, 16'h8000, 5'h01},
        '{16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 5'h00},
        '{16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 5'h00},
        '{16'h4000, 16'h3C00, 1'b1, 16'h3C00, 5'h00},
        '{16'h3C00, 16'h4000, 1'b1, 16'hBC00, 5'h00},
        '{16'h0400, 16'h0001, 1'b1, 16'h03FF, 5'h00},
        '{16'h3C00, 16'h0001, 1'b0, 16'h3C00, 5'h02},
        '{16'h4400, 16'h3C01, 1'b1, 16'h4200, 5'h02},
        '{16'h3C00, 16'h3800, 1'b0, 16'h3E00, 5'h00},
        '{16'hFBFF, 16'hFBFF, 1'b0, 16'hFC00, 5'h0A},
        '{16'h3C00, 16'hFC00, 1'b0, 16'hFC00, 5'h00}
    };

    fp_addsub_pipe #(.EXP_W(EW), .FRAC_W(FW), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    // one cycle: sample handshakes mid-cycle, then step past the rising edge
    task automatic tick(output bit acc, output bit cons, output bit ov, output exp_t got);
        @(negedge clk);
        acc  = in_valid & in_ready;
        cons = out_valid & out_ready;
        ov   = out_valid;
        got  = {out_result, out_tag, out_flags};
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [TW-1:0] tag);
        in_valid = 1'b1;
        in_a     = vt[i].a;
        in_b     = vt[i].b;
        in_mode  = vt[i].mode;
        in_tag   = tag;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL rst_hold_valid got=%b want=0", out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL rst_in_ready got=%b want=1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL rst_out_valid got=%b want=0", out_valid);
        end
        checks++;
        if ({out_result, out_tag, out_flags} !== '0) begin
            failures++;
            $display("FAIL rst_outputs got=%h/%h/%h want=0/0/0", out_result, out_tag, out_flags);
        end
    endtask

    task automatic test_latency();
        bit acc, cons, ov;
        exp_t got;
        int n;
        out_ready = 1'b1;
        drive(0, 4'd3);
        tick(acc, cons, ov, got);
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            failures++; $display("FAIL lat_accept got=%b want=1", acc);
        end
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 3) begin
            failures++; $display("FAIL lat_cycles got=%0d want=3", n);
        end
        checks++;
        if ({out_result, out_tag, out_flags} !== {16'h4000, 4'd3, 5'h00}) begin
            failures++;
            $display("FAIL lat_result got=%h/%h/%h want=4000/3/00", out_result, out_tag, out_flags);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL lat_drain got=%b want=0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        bit acc, cons, ov;
        exp_t got, e;
        int sent = 0, rcvd = 0, cyc = 0;
        out_ready = 1'b1;
        while (rcvd < NV && cyc < 200) begin
            if (sent < NV) drive(sent, TW'(sent + 5));
            else           in_valid = 1'b0;
            tick(acc, cons, ov, got);
            if (acc) begin
                sbq.push_back({vt[sent].res, TW'(sent + 5), vt[sent].flg});
                sent++;
            end
            if (cons) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++; $display("FAIL b2b_unexpected got=%h", got);
                end else begin
                    e = sbq.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("FAIL b2b_vec%0d got=%h/%h/%h want=%h/%h/%h", rcvd,
                                 got.res, got.tag, got.flg, e.res, e.tag, e.flg);
                    end
                end
                rcvd++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (rcvd != NV) begin
            failures++; $display("FAIL b2b_timeout got=%0d want=%0d", rcvd, NV);
        end
        checks++;
        if (cyc != NV + 3) begin
            failures++; $display("FAIL b2b_throughput cycles=%0d want=%0d", cyc, NV + 3);
        end
    endtask

    task automatic test_backpressure();
        bit acc, cons, ov, have_hold = 1'b0;
        exp_t got, hold, e;
        int sent = 0, rcvd = 0, cyc = 0;
        hold = '0;
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (sent < 5) drive(sent, TW'(10 + sent));
            else          in_valid = 1'b0;
            tick(acc, cons, ov, got);
            if (acc) begin
                sbq.push_back({vt[sent].res, TW'(10 + sent), vt[sent].flg});
                sent++;
            end
            if (ov) begin
                if (have_hold) begin
                    checks++;
                    if (got !== hold) begin
                        failures++; $display("FAIL bp_stable got=%h want=%h", got, hold);
                    end
                end else begin
                    hold      = got;
                    have_hold = 1'b1;
                end
            end
        end
        checks++;
        if (sent != 3) begin
            failures++; $display("FAIL bp_accepted got=%0d want=3", sent);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_in_ready got=%b want=0", in_ready);
        end
        out_ready = 1'b1;
        while (rcvd < 5 && cyc < 40) begin
            if (sent < 5) drive(sent, TW'(10 + sent));
            else          in_valid = 1'b0;
            tick(acc, cons, ov, got);
            if (acc) begin
                sbq.push_back({vt[sent].res, TW'(10 + sent), vt[sent].flg});
                sent++;
            end
            if (cons) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++; $display("FAIL bp_unexpected got=%h", got);
                end else begin
                    e = sbq.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("FAIL bp_order%0d got=%h/%h/%h want=%h/%h/%h", rcvd,
                                 got.res, got.tag, got.flg, e.res, e.tag, e.flg);
                    end
                end
                rcvd++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (rcvd != 5) begin
            failures++; $display("FAIL bp_drain got=%0d want=5", rcvd);
        end
    endtask

    task automatic test_reset_midflight();
        bit acc, cons, ov;
        exp_t got;
        int stale = 0;
        out_ready = 1'b1;
        drive(0, 4'd1);
        tick(acc, cons, ov, got);
        drive(3, 4'd2);
        tick(acc, cons, ov, got);
        in_valid = 1'b0;
        tick(acc, cons, ov, got);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL mid_inflight got=%b want=1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL mid_valid_drop got=%b want=0", out_valid);
        end
        checks++;
        if (out_result !== 16'h0000) begin
            failures++; $display("FAIL mid_result_clear got=%h want=0000", out_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL mid_in_ready got=%b want=1", in_ready);
        end
        for (int c = 0; c < 8; c++) begin
            tick(acc, cons, ov, got);
            if (ov) stale++;
        end
        checks++;
        if (stale != 0) begin
            failures++; $display("FAIL mid_stale got=%0d want=0", stale);
        end
        sbq.delete();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754 binary floating-point adder/subtractor for the accelerator datapath. It supersedes the single-format combinational fp16 adder.
- Adds: generic exponent/fraction widths, round-to-nearest-even with guard/round/sticky, full special-value handling, exception flags, and valid/ready flow control with a pass-through tag.

Parameters:
- EXP_W, 5, exponent field width (>=3)
- FRAC_W, 10, stored fraction width (>=2); word width W = 1+EXP_W+FRAC_W
- TAG_W, 4, width of the opaque tag carried alongside each operation

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid & in_ready
- in_mode  in  1  0 = a+b, 1 = a-b (sign of b inverted before use)
- in_a  in  W  operand a
- in_b  in  W  operand b
- in_tag  in  TAG_W  returned unchanged with the result
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid & out_ready
- out_result  out  W  rounded result
- out_tag  out  TAG_W  tag of this result
- out_flags  out  5  {invalid, overflow, underflow, inexact, zero}

Behaviour:
- Reset: all stage valid bits 0. out_valid=0, out_result=0, out_tag=0, out_flags=0. in_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation discards all in-flight operations; none are emitted.
- Pipeline stages:
  - S1 (unpack/align): classify each operand as zero/subnormal/normal/inf/NaN. Subnormal effective exponent = 1 with hidden bit 0. Swap so |big|>=|small| (compare exponent, then fraction). Right-shift the small significand by the exponent difference into FRAC_W+1 bits plus guard, round and sticky. Shift >= FRAC_W+3 leaves only sticky (set if small is nonzero).
  - S2 (add/LZC): effective subtract = sign_big ^ sign_small. Compute the FRAC_W+5-bit sum/difference, then the leading-zero count.
  - S3 (normalise/round/pack):
    - Carry-out: right-shift 1, exponent+1, folding the shifted-out bit into sticky.
    - Otherwise left-shift by min(LZC, exp_big-1). If the result is still below hidden-bit position, emit a subnormal with exponent field 0.
    - Round to nearest, ties to even. A rounding carry that overflows the significand increments the exponent.
- Latency: exactly 3 cycles from accept to out_valid when out_ready stays 1. Throughput is 1 op/cycle.
- Flow control:
  - Each stage advances when the next stage is empty or advancing. Stage 3 advances when ~out_valid | out_ready.
  - in_ready = ~s1_valid | s1_advance. in_ready is combinational from out_ready through the stage chain.
  - Results leave in acceptance order.
  - out_result, out_tag and out_flags are held stable while out_valid & ~out_ready.
- Special cases (resolved in S1, carried as a bypass through the pipe):
  - Any NaN operand → canonical qNaN: sign 0, exponent all ones, fraction MSB 1, rest 0. invalid=1 only if an input was a signalling NaN.
  - inf + (-inf) effective → canonical qNaN, invalid=1.
  - inf with any finite value → that inf, no flags.
- Exact zero result:
  - x + (-x) → +0 with zero=1.
  - (-0) + (-0) → -0 with zero=1.
- Overflow: a rounded exponent >= all-ones gives ±inf with overflow=1 and inexact=1.
- Underflow: set when the result is tiny (subnormal or zero before rounding, nonzero exact) and inexact.
- inexact: set when any of guard, round or sticky is nonzero after normalisation.
- Result sign: sign of the larger-magnitude operand, except for the exact zero cases above.

Optional Feature:
- Macro FP_ADDSUB_FTZ_EN.
- When defined: subnormal inputs are treated as signed zero in S1. Any result that would be subnormal after rounding is flushed to zero with the sign preserved, and underflow=1, inexact=1. The subnormal shift-limit logic is omitted.
- When undefined: full gradual underflow as described in Behaviour.

Test Plan:
- 0x3C00 + 0x3C00, mode 0, tag 3 → 0x4000 with tag 3 and flags 0, out_valid exactly 3 cycles after accept.
- 0x3C00 − 0x3C00 (mode 1) → 0x0000, zero=1. 0x0001 + 0x0001 → 0x0002 (FTZ off), or 0x0000 with underflow=1, inexact=1 (FTZ on).
- Rounding:
  - 0x3C00 + 0x1000 (1 + 2^-11, tie) → 0x3C00, inexact=1.
  - 0x3C01 + 0x1000 → 0x3C02, inexact=1.
- 0x7BFF + 0x7BFF → 0x7C00 with overflow=1, inexact=1. 0x7C00 − 0x7C00 → 0x7E00 with invalid=1. 0x7D00 + 0x3C00 → 0x7E00 with invalid=1.
- Backpressure:
  - Hold out_ready=0 and stream 5 ops. Exactly 3 are accepted, then in_ready=0.
  - Release out_ready: all 5 results appear in order, each with its correct tag.
  - Outputs stay stable while stalled.
- Assert rst_n low with 2 ops in flight → out_valid=0 immediately, and no stale results after rst_n rises.
